// File: rtl/fram_arb_pkg.sv
// Shared types and width helpers for the banked feature-RAM arbiter.
package fram_arb_pkg;

  localparam int unsigned BankIdxW = 8;

  typedef logic [BankIdxW-1:0] bank_idx_t;

  // One slot of the per-port read-return pipeline.
  typedef struct packed {
    logic      valid;
    bank_idx_t bank;
  } pipe_entry_t;

  function automatic int unsigned bank_sel_width(input int unsigned bank_num);
    return (bank_num > 1) ? $clog2(bank_num) : 1;
  endfunction

  function automatic int unsigned offset_width(input int unsigned addr_width,
                                               input int unsigned bank_num);
    return addr_width - bank_sel_width(bank_num);
  endfunction

endpackage

// File: rtl/fram_rr_arb.sv
// Per-bank round-robin picker among read ports; urgent requests pre-empt, hold_i blocks
// non-urgent reads so a pending write can take the bank.
module fram_rr_arb #(
  parameter int unsigned RP_NUM = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RP_NUM-1:0] req_i,
  input  logic [RP_NUM-1:0] urgent_i,
  input  logic              hold_i,
  output logic [RP_NUM-1:0] gnt_o
);

  localparam int unsigned PtrW = (RP_NUM > 1) ? $clog2(RP_NUM) : 1;

  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [PtrW-1:0]   idx;
  logic [RP_NUM-1:0] cand;

  function automatic int unsigned wrap(input int unsigned v);
    return (v >= RP_NUM) ? v - RP_NUM : v;
  endfunction

  always_comb begin
    cand  = (|urgent_i) ? urgent_i : (hold_i ? '0 : req_i);
    gnt_o = '0;
    ptr_d = ptr_q;
    idx   = '0;
    for (int unsigned k = 0; k < RP_NUM; k++) begin
      idx = PtrW'(wrap(32'(ptr_q) + k));
      if (gnt_o == '0 && cand[idx]) begin
        gnt_o[idx] = 1'b1;
        ptr_d      = PtrW'(wrap(32'(idx) + 1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/fram_arbiter.sv
// Banked feature-RAM arbiter: RP_NUM read ports and one write port onto BANK_NUM BRAMs.
// Define FRAM_ARB_PERF_EN to add the saturating conflict_cnt output.
module fram_arbiter
  import fram_arb_pkg::*;
#(
  parameter int unsigned BANK_NUM   = 4,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned RP_NUM     = 2,
  parameter int unsigned BRAM_LAT   = 1,
  parameter int unsigned WAIT_MAX   = 7,
  localparam int unsigned OffW      = offset_width(ADDR_WIDTH, BANK_NUM)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [RP_NUM-1:0]                    rp_valid,
  input  logic [RP_NUM-1:0][ADDR_WIDTH-1:0]    rp_addr,
  output logic [RP_NUM-1:0]                    rp_ready,
  output logic [RP_NUM-1:0]                    rp_rvalid,
  output logic [RP_NUM-1:0][DATA_WIDTH-1:0]    rp_rdata,
  input  logic                                 wp_valid,
  input  logic [ADDR_WIDTH-1:0]                wp_addr,
  input  logic [DATA_WIDTH-1:0]                wp_wdata,
  output logic                                 wp_ready,
  output logic [BANK_NUM-1:0][OffW-1:0]        bram_addr,
  output logic [BANK_NUM-1:0][DATA_WIDTH-1:0]  bram_wdata,
  output logic [BANK_NUM-1:0]                  bram_we,
  output logic [BANK_NUM-1:0]                  bram_en,
  input  logic [BANK_NUM-1:0][DATA_WIDTH-1:0]  bram_rdata
`ifdef FRAM_ARB_PERF_EN
  ,
  output logic [31:0]                          conflict_cnt
`endif
);

  localparam int unsigned SelW = bank_sel_width(BANK_NUM);
  localparam int unsigned CntW = $clog2(WAIT_MAX + 1);

  typedef logic [CntW-1:0] wait_t;
  localparam wait_t WaitMax = wait_t'(WAIT_MAX);

  logic [RP_NUM-1:0][SelW-1:0]   rp_bank;
  logic [RP_NUM-1:0][OffW-1:0]   rp_off;
  logic [SelW-1:0]               wp_bank;
  logic [OffW-1:0]               wp_off;

  wait_t [RP_NUM-1:0]            wait_q, wait_d;
  logic  [RP_NUM-1:0]            urgent;

  logic [BANK_NUM-1:0][RP_NUM-1:0] bank_req, bank_urg, bank_gnt;
  logic [BANK_NUM-1:0]             bank_wr, bank_wgnt;

  pipe_entry_t [RP_NUM-1:0][BRAM_LAT-1:0] pipe_q, pipe_d;

  always_comb begin
    for (int p = 0; p < RP_NUM; p++) begin
      rp_bank[p] = rp_addr[p][ADDR_WIDTH-1 -: SelW];
      rp_off[p]  = rp_addr[p][OffW-1:0];
    end
    wp_bank = wp_addr[ADDR_WIDTH-1 -: SelW];
    wp_off  = wp_addr[OffW-1:0];
  end

  always_comb begin
    urgent   = '0;
    bank_req = '0;
    bank_urg = '0;
    bank_wr  = '0;
    for (int p = 0; p < RP_NUM; p++) begin
      urgent[p] = (wait_q[p] == WaitMax);
    end
    for (int b = 0; b < BANK_NUM; b++) begin
      bank_wr[b] = wp_valid && (wp_bank == SelW'(b));
      for (int p = 0; p < RP_NUM; p++) begin
        bank_req[b][p] = rp_valid[p] && (rp_bank[p] == SelW'(b));
        bank_urg[b][p] = bank_req[b][p] && urgent[p];
      end
    end
  end

  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
    fram_rr_arb #(
      .RP_NUM(RP_NUM)
    ) u_rr_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_i   (bank_req[b]),
      .urgent_i(bank_urg[b]),
      .hold_i  (bank_wr[b]),
      .gnt_o   (bank_gnt[b])
    );
  end

  // A starved read in the bank takes precedence over the write.
  always_comb begin
    rp_ready   = '0;
    wp_ready   = 1'b0;
    bram_en    = '0;
    bram_we    = '0;
    bram_addr  = '0;
    bram_wdata = '0;
    bank_wgnt  = '0;
    if (rst_n) begin
      for (int b = 0; b < BANK_NUM; b++) begin
        bank_wgnt[b] = bank_wr[b] && !(|bank_urg[b]);
        if (bank_wgnt[b]) begin
          bram_en[b]    = 1'b1;
          bram_we[b]    = 1'b1;
          bram_addr[b]  = wp_off;
          bram_wdata[b] = wp_wdata;
        end else begin
          for (int p = 0; p < RP_NUM; p++) begin
            if (bank_gnt[b][p]) begin
              bram_en[b]   = 1'b1;
              bram_addr[b] = rp_off[p];
              rp_ready[p]  = 1'b1;
            end
          end
        end
      end
      wp_ready = |bank_wgnt;
    end
  end

  always_comb begin
    for (int p = 0; p < RP_NUM; p++) begin
      if (!rp_valid[p] || rp_ready[p]) begin
        wait_d[p] = '0;
      end else if (wait_q[p] == WaitMax) begin
        wait_d[p] = wait_q[p];
      end else begin
        wait_d[p] = wait_q[p] + wait_t'(1);
      end
    end
  end

  always_comb begin
    pipe_d = pipe_q;
    for (int p = 0; p < RP_NUM; p++) begin
      pipe_d[p][0].valid = rp_ready[p];
      pipe_d[p][0].bank  = bank_idx_t'(rp_bank[p]);
      for (int s = 1; s < BRAM_LAT; s++) begin
        pipe_d[p][s] = pipe_q[p][s-1];
      end
    end
  end

  always_comb begin
    rp_rvalid = '0;
    rp_rdata  = '0;
    for (int p = 0; p < RP_NUM; p++) begin
      rp_rvalid[p] = pipe_q[p][BRAM_LAT-1].valid;
      for (int b = 0; b < BANK_NUM; b++) begin
        if (pipe_q[p][BRAM_LAT-1].valid && pipe_q[p][BRAM_LAT-1].bank == bank_idx_t'(b)) begin
          rp_rdata[p] = bram_rdata[b];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
      pipe_q <= '0;
    end else begin
      wait_q <= wait_d;
      pipe_q <= pipe_d;
    end
  end

`ifdef FRAM_ARB_PERF_EN
  logic [31:0] conflict_q, conflict_d;
  logic        conflict;

  always_comb begin
    conflict   = (|(rp_valid & ~rp_ready)) || (wp_valid && !wp_ready);
    conflict_d = conflict_q;
    if (conflict && conflict_q != 32'hFFFF_FFFF) begin
      conflict_d = conflict_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_q <= '0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_fram_arbiter.sv
// Bench for fram_arbiter: a flat-memory reference model checked every cycle against two
// instances (BRAM_LAT 1 and 3), plus directed scenarios with literal expectations.
module tb_fram_arbiter;

  localparam int BN = 4;
  localparam int AW = 12;
  localparam int DW = 16;
  localparam int RP = 2;
  localparam int OW = 10;
  localparam int WM = 7;

  logic clk = 1'b0;
  logic rst_n;
  logic [RP-1:0]         rp_valid;
  logic [RP-1:0][AW-1:0] rp_addr;
  logic                  wp_valid;
  logic [AW-1:0]         wp_addr;
  logic [DW-1:0]         wp_wdata;

  logic [RP-1:0]         rp_ready_a, rp_rvalid_a, rp_ready_c, rp_rvalid_c;
  logic [RP-1:0][DW-1:0] rp_rdata_a, rp_rdata_c;
  logic                  wp_ready_a, wp_ready_c;
  logic [BN-1:0][OW-1:0] bram_addr_a, bram_addr_c;
  logic [BN-1:0][DW-1:0] bram_wdata_a, bram_wdata_c, bram_rdata_a, bram_rdata_c;
  logic [BN-1:0]         bram_we_a, bram_en_a, bram_we_c, bram_en_c;
`ifdef FRAM_ARB_PERF_EN
  logic [31:0]           conflict_cnt_a, conflict_cnt_c;
`endif

  always #5 clk = ~clk;

  fram_arbiter #(.BANK_NUM(BN), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RP_NUM(RP),
                 .BRAM_LAT(1), .WAIT_MAX(WM)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .rp_valid(rp_valid), .rp_addr(rp_addr),
    .rp_ready(rp_ready_a), .rp_rvalid(rp_rvalid_a), .rp_rdata(rp_rdata_a),
    .wp_valid(wp_valid), .wp_addr(wp_addr), .wp_wdata(wp_wdata), .wp_ready(wp_ready_a),
    .bram_addr(bram_addr_a), .bram_wdata(bram_wdata_a), .bram_we(bram_we_a),
    .bram_en(bram_en_a), .bram_rdata(bram_rdata_a)
`ifdef FRAM_ARB_PERF_EN
    , .conflict_cnt(conflict_cnt_a)
`endif
  );

  fram_arbiter #(.BANK_NUM(BN), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RP_NUM(RP),
                 .BRAM_LAT(3), .WAIT_MAX(WM)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .rp_valid(rp_valid), .rp_addr(rp_addr),
    .rp_ready(rp_ready_c), .rp_rvalid(rp_rvalid_c), .rp_rdata(rp_rdata_c),
    .wp_valid(wp_valid), .wp_addr(wp_addr), .wp_wdata(wp_wdata), .wp_ready(wp_ready_c),
    .bram_addr(bram_addr_c), .bram_wdata(bram_wdata_c), .bram_we(bram_we_c),
    .bram_en(bram_en_c), .bram_rdata(bram_rdata_c)
`ifdef FRAM_ARB_PERF_EN
    , .conflict_cnt(conflict_cnt_c)
`endif
  );

  function automatic logic [DW-1:0] h(input int a);
    return DW'((a * 40503) ^ 32'h5a3c ^ (a >> 3));
  endfunction

  // BRAM models; contents reload from h() whenever reset is low.
  logic [DW-1:0] mem_a [BN][1<<OW];
  logic [DW-1:0] mem_c [BN][1<<OW];
  logic [BN-1:0][DW-1:0] rd_a, rd_c0, rd_c1, rd_c2;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < BN; b++)
        for (int o = 0; o < (1 << OW); o++) begin
          mem_a[b][o] <= h(b * (1 << OW) + o);
          mem_c[b][o] <= h(b * (1 << OW) + o);
        end
    end else begin
      for (int b = 0; b < BN; b++) begin
        if (bram_en_a[b] && bram_we_a[b]) mem_a[b][bram_addr_a[b]] <= bram_wdata_a[b];
        else if (bram_en_a[b]) rd_a[b] <= mem_a[b][bram_addr_a[b]];
        if (bram_en_c[b] && bram_we_c[b]) mem_c[b][bram_addr_c[b]] <= bram_wdata_c[b];
        else if (bram_en_c[b]) rd_c0[b] <= mem_c[b][bram_addr_c[b]];
      end
    end
    rd_c1 <= rd_c0;
    rd_c2 <= rd_c1;
  end

  assign bram_rdata_a = rd_a;
  assign bram_rdata_c = rd_c2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: flat memory, per-bank pointer, per-port wait count, response queues.
  typedef struct packed {
    int          due;
    logic [DW-1:0] d;
  } resp_t;

  logic [DW-1:0] fmem [1<<AW];
  int            ptr [BN];
  int            wt [RP];
  resp_t         qa [RP][$];
  resp_t         qc [RP][$];
  logic [31:0]   ccnt;
  int            win, p2;
  bit            wr, urg;
  resp_t         r;

  logic [RP-1:0]         e_rdy, e_rv_a, e_rv_c;
  logic [RP-1:0][DW-1:0] e_rd_a, e_rd_c;
  logic                  e_wrdy;
  logic [BN-1:0]         e_en, e_we;
  logic [BN-1:0][OW-1:0] e_addr;
  logic [BN-1:0][DW-1:0] e_wdata;

  function automatic int bank_of(input logic [AW-1:0] a);
    return int'(a) / (1 << OW);
  endfunction

  always @(negedge clk) begin
    cyc++;
    e_rdy = '0; e_rv_a = '0; e_rv_c = '0; e_rd_a = '0; e_rd_c = '0; e_wrdy = 1'b0;
    e_en = '0; e_we = '0; e_addr = '0; e_wdata = '0;
    if (!rst_n) begin
      for (int b = 0; b < BN; b++) ptr[b] = 0;
      for (int p = 0; p < RP; p++) begin
        wt[p] = 0;
        qa[p].delete();
        qc[p].delete();
      end
      ccnt = '0;
      for (int a = 0; a < (1 << AW); a++) fmem[a] = h(a);
    end else begin
      for (int p = 0; p < RP; p++) begin
        if (qa[p].size() > 0 && qa[p][0].due == cyc) begin
          e_rv_a[p] = 1'b1;
          e_rd_a[p] = qa[p][0].d;
          void'(qa[p].pop_front());
        end
        if (qc[p].size() > 0 && qc[p][0].due == cyc) begin
          e_rv_c[p] = 1'b1;
          e_rd_c[p] = qc[p][0].d;
          void'(qc[p].pop_front());
        end
      end
      for (int b = 0; b < BN; b++) begin
        wr  = wp_valid && bank_of(wp_addr) == b;
        urg = 1'b0;
        for (int p = 0; p < RP; p++)
          if (rp_valid[p] && bank_of(rp_addr[p]) == b && wt[p] >= WM) urg = 1'b1;
        win = -1;
        for (int k = 0; k < RP; k++) begin
          p2 = (ptr[b] + k) % RP;
          if (win < 0 && rp_valid[p2] && bank_of(rp_addr[p2]) == b &&
              (urg ? wt[p2] >= WM : !wr)) win = p2;
        end
        if (wr && !urg) begin
          e_wrdy     = 1'b1;
          e_en[b]    = 1'b1;
          e_we[b]    = 1'b1;
          e_addr[b]  = wp_addr[OW-1:0];
          e_wdata[b] = wp_wdata;
        end else if (win >= 0) begin
          e_en[b]     = 1'b1;
          e_addr[b]   = rp_addr[win][OW-1:0];
          e_rdy[win]  = 1'b1;
          ptr[b]      = (win + 1) % RP;
          r.d   = fmem[rp_addr[win]];
          r.due = cyc + 1;
          qa[win].push_back(r);
          r.due = cyc + 3;
          qc[win].push_back(r);
        end
      end
      if (e_wrdy) fmem[wp_addr] = wp_wdata;
      for (int p = 0; p < RP; p++) wt[p] = (!rp_valid[p] || e_rdy[p]) ? 0 : wt[p] + 1;
      if ((|(rp_valid & ~e_rdy)) || (wp_valid && !e_wrdy))
        if (ccnt != 32'hFFFF_FFFF) ccnt = ccnt + 1;
    end
    chk("rp_ready",   {rp_ready_c, rp_ready_a}, {e_rdy, e_rdy});
    chk("wp_ready",   {wp_ready_c, wp_ready_a}, {e_wrdy, e_wrdy});
    chk("bram_en",    {bram_en_c, bram_en_a},   {e_en, e_en});
    chk("bram_we",    {bram_we_c, bram_we_a},   {e_we, e_we});
    chk("bram_addr_a",  bram_addr_a,  e_addr);
    chk("bram_addr_c",  bram_addr_c,  e_addr);
    chk("bram_wdata_a", bram_wdata_a, e_wdata);
    chk("bram_wdata_c", bram_wdata_c, e_wdata);
    chk("rvalid_lat1", rp_rvalid_a, e_rv_a);
    chk("rdata_lat1",  rp_rdata_a,  e_rd_a);
    chk("rvalid_lat3", rp_rvalid_c, e_rv_c);
    chk("rdata_lat3",  rp_rdata_c,  e_rd_c);
`ifdef FRAM_ARB_PERF_EN
    chk("conflict_cnt", {conflict_cnt_c, conflict_cnt_a}, {ccnt, ccnt});
`endif
  end

  task automatic clear_inputs();
    rp_valid = '0; rp_addr = '0; wp_valid = 1'b0; wp_addr = '0; wp_wdata = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    clear_inputs();
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic rand_cycle(input int wprob);
    for (int p = 0; p < RP; p++)
      if ($urandom_range(3) == 0) begin
        rp_valid[p] = 1'($urandom_range(1));
        rp_addr[p]  = AW'(($urandom_range(3) << OW) | $urandom_range(7));
      end
    if ($urandom_range(3) == 0) begin
      wp_valid = ($urandom_range(99) < wprob);
      wp_addr  = AW'(($urandom_range(3) << OW) | $urandom_range(7));
      wp_wdata = DW'($urandom);
    end
  endtask

  logic [RP-1:0] rr_exp [4];

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Idle after reset: nothing moves.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk("idle_rvalid", {rp_rvalid_c, rp_rvalid_a}, '0);
      chk("idle_bram_en", {bram_en_c, bram_en_a}, '0);
    end

    // Two reads to different banks in one cycle.
    @(posedge clk); #1;
    rp_valid = 2'b11; rp_addr[0] = 12'h004; rp_addr[1] = 12'h404;
    @(negedge clk); #1;
    chk("dual_ready", rp_ready_a, 2'b11);
    chk("dual_bram_en", bram_en_a, 4'b0011);
    chk("dual_addr0", bram_addr_a[0], 10'h004);
    chk("dual_addr1", bram_addr_a[1], 10'h004);
    @(posedge clk); #1;
    rp_valid = '0;
    @(negedge clk); #1;
    chk("dual_rvalid", rp_rvalid_a, 2'b11);
    chk("dual_rdata", rp_rdata_a, {h(12'h404), h(12'h004)});

    // Round-robin on a shared bank.
    do_reset();
    @(posedge clk); #1;
    rp_valid = 2'b11; rp_addr[0] = 12'h800; rp_addr[1] = 12'h804;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("rr_seq", rp_ready_a, rr_exp[i]);
      @(posedge clk); #1;
    end
    clear_inputs();

    // Write held against a read on bank 1: read wins once its wait reaches WAIT_MAX.
    do_reset();
    @(posedge clk); #1;
    wp_valid = 1'b1; wp_addr = 12'h500; wp_wdata = 16'hBEEF;
    rp_valid = 2'b01; rp_addr[0] = 12'h480;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); #1;
      chk("starve_wp_ready", wp_ready_a, (i != 7));
      chk("starve_rp_ready", rp_ready_a, (i == 7) ? 2'b01 : 2'b00);
      @(posedge clk); #1;
    end
    clear_inputs();

    // Reset one cycle after a grant drops the in-flight read.
    do_reset();
    @(posedge clk); #1;
    rp_valid = 2'b01; rp_addr[0] = 12'h123;
    @(negedge clk); #1;
    chk("lat3_grant", rp_ready_c, 2'b01);
    @(posedge clk); #1;
    rp_valid = '0;
    #1 rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      chk("rst_drop_rvalid", {rp_rvalid_c, rp_rvalid_a}, '0);
    end

`ifdef FRAM_ARB_PERF_EN
    do_reset();
    @(posedge clk); #1;
    rp_valid = 2'b11; rp_addr[0] = 12'h800; rp_addr[1] = 12'h804;
    repeat (5) @(posedge clk);
    #1 clear_inputs();
    @(negedge clk); #1;
    chk("conflict_five", conflict_cnt_a, 32'd5);
`endif

    // Randomized traffic, then write-heavy traffic to exercise starvation.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      rand_cycle(40);
    end
    do_reset();
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      rand_cycle(95);
    end
    @(posedge clk); #1;
    clear_inputs();
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
